// File: rtl/neuron_weight_mult_pkg.sv
// Shared fixed-point defaults, Q16.16 constants and FSM state encodings for the neuron stages.
package neuron_weight_mult_pkg;

    localparam int NWM_DATA_W    = 32;
    localparam int NWM_FRAC_BITS = 16;
    localparam int NWM_LANES     = 4;

    localparam logic [31:0] FX_ONE = 32'h0001_0000;
    localparam logic [31:0] FX_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] FX_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } nwm_state_e;

endpackage

// File: rtl/neuron_weight_mult_fx_mul_sat.sv
// Combinational signed fixed-point multiply: (a*b) >>> FRAC_BITS, saturated to DATA_W bits.
module fx_mul_sat #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    localparam logic signed [2*DATA_W-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [2*DATA_W-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] full;
    logic signed [2*DATA_W-1:0] shifted;

    assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign full  = a_ext * b_ext;
    // Arithmetic shift floors toward -inf, so -0.5 LSB becomes -1 LSB.
    assign shifted = full >>> FRAC_BITS;

    always_comb begin
        if (shifted > SAT_MAX) begin
            y_o = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            y_o = SAT_MIN[DATA_W-1:0];
        end else begin
            y_o = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/neuron_weight_mult.sv
// Four-lane weight multiplier sharing one fx_mul_sat; publishes all products with a done pulse.
//   state   | meaning
//   IDLE    | waiting for start, operands captured on accept
//   MUL     | one lane per cycle through the shared multiplier
//   DONE    | products valid, done pulse, back to IDLE
import neuron_weight_mult_pkg::*;

module neuron_weight_mult #(
    parameter int DATA_W    = NWM_DATA_W,
    parameter int FRAC_BITS = NWM_FRAC_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2,
    input  logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] prod0,
    output logic [DATA_W-1:0] prod1,
    output logic [DATA_W-1:0] prod2,
    output logic [DATA_W-1:0] prod3,
    output logic              busy,
    output logic              done
);

    nwm_state_e        state_q, state_d;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] x_q       [NWM_LANES];
    logic [DATA_W-1:0] w_q       [NWM_LANES];
    logic [DATA_W-1:0] p_stage_q [NWM_LANES];
    logic [DATA_W-1:0] prod_q    [NWM_LANES];
    logic [DATA_W-1:0] x_in      [NWM_LANES];
    logic [DATA_W-1:0] w_in      [NWM_LANES];
    logic [DATA_W-1:0] mul_y;
    logic              load_en, mul_en, last_lane;

    assign x_in[0] = x0;
    assign x_in[1] = x1;
    assign x_in[2] = x2;
    assign x_in[3] = x3;
    assign w_in[0] = w0;
    assign w_in[1] = w1;
    assign w_in[2] = w2;
    assign w_in[3] = w3;

    fx_mul_sat #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_mul (
        .a_i (x_q[lane_q]),
        .b_i (w_q[lane_q]),
        .y_o (mul_y)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_MUL;
            ST_MUL:  if (lane_q == 2'd3) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        mul_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: load_en = start;
            ST_MUL: begin
                mul_en = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign last_lane = mul_en && (lane_q == 2'd3);

    // Lane 3 bypasses its staging reg so all products are already valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_q <= '0;
            for (int i = 0; i < NWM_LANES; i++) begin
                x_q[i]       <= '0;
                w_q[i]       <= '0;
                p_stage_q[i] <= '0;
                prod_q[i]    <= '0;
            end
        end else begin
            if (load_en) begin
                lane_q <= '0;
                for (int i = 0; i < NWM_LANES; i++) begin
                    x_q[i] <= x_in[i];
                    w_q[i] <= w_in[i];
                end
            end
            if (mul_en) begin
                lane_q            <= lane_q + 2'd1;
                p_stage_q[lane_q] <= mul_y;
            end
            if (last_lane) begin
                prod_q[0] <= p_stage_q[0];
                prod_q[1] <= p_stage_q[1];
                prod_q[2] <= p_stage_q[2];
                prod_q[3] <= mul_y;
            end
        end
    end

    assign prod0 = prod_q[0];
    assign prod1 = prod_q[1];
    assign prod2 = prod_q[2];
    assign prod3 = prod_q[3];

endmodule

// File: tb/tb_neuron_weight_mult.sv
// Directed-vector bench for neuron_weight_mult with hand-computed Q16.16 products.
module tb_neuron_weight_mult;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic [31:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic [31:0] prod0, prod1, prod2, prod3;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    logic [31:0] xs [4];
    logic [31:0] ws [4];
    logic [31:0] pe [4];
    logic [31:0] prev_p [4];

    always #5 clk = ~clk;

    neuron_weight_mult dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x0    (x0), .x1 (x1), .x2 (x2), .x3 (x3),
        .w0    (w0), .w1 (w1), .w2 (w2), .w3 (w3),
        .prod0 (prod0), .prod1 (prod1), .prod2 (prod2), .prod3 (prod3),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic drive_ops(input logic [31:0] xv [4], input logic [31:0] wv [4]);
        x0 = xv[0]; x1 = xv[1]; x2 = xv[2]; x3 = xv[3];
        w0 = wv[0]; w1 = wv[1]; w2 = wv[2]; w3 = wv[3];
    endtask

    task automatic chk_prods(input string tag, input logic [31:0] ev [4]);
        chk({tag, "_p0"}, prod0, ev[0]);
        chk({tag, "_p1"}, prod1, ev[1]);
        chk({tag, "_p2"}, prod2, ev[2]);
        chk({tag, "_p3"}, prod3, ev[3]);
    endtask

    // mode 0: plain job; mode 1: junk inputs at T+1 and start pulses at T+2 and T+5
    task automatic run_job(input string tag, input int mode);
        logic [31:0] junk [4];
        junk = '{32'h7FFF0000, 32'h12345678, 32'h80000000, 32'hDEADBEEF};
        @(negedge clk);
        drive_ops(xs, ws);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_done"}, {31'd0, done}, {31'd0, (n == 5)});
            if (n == 1) chk({tag, "_hold"}, prod0, prev_p[0]);
            if (mode == 1) begin
                if (n == 1) drive_ops(junk, junk);
                if (n == 2) start = 1'b1;
                if (n == 3) start = 1'b0;
                if (n == 5) start = 1'b1;
            end
            if (n < 5) @(negedge clk);
        end
        chk_prods(tag, pe);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, done}, 32'd0);
        if (mode == 1) begin
            @(negedge clk);
            chk({tag, "_nojob"}, {31'd0, busy}, 32'd0);
            chk_prods({tag, "_kept"}, pe);
        end
        prev_p = pe;
    endtask

    initial begin
        int ndone;
        int last;
        logic [31:0] pa [4];
        logic [31:0] pb [4];

        prev_p = '{32'h0, 32'h0, 32'h0, 32'h0};
        repeat (2) @(negedge clk);
        chk_prods("rst", prev_p);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;

        xs = '{32'h00010000, 32'h00020000, 32'hFFFE8000, 32'h00008000};
        ws = '{32'h00028000, 32'h00028000, 32'h00028000, 32'h00028000};
        pe = '{32'h00028000, 32'h00050000, 32'hFFFC4000, 32'h00014000};
        run_job("basic", 0);

        xs = '{32'h7FFF0000, 32'h80000000, 32'h80000000, 32'h00030000};
        ws = '{32'h00020000, 32'h00020000, 32'hFFFF0000, 32'hFFFF8000};
        pe = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFE8000};
        run_job("sat", 0);

        xs = '{32'h00000001, 32'hFFFFFFFF, 32'h00018000, 32'hFFFF0000};
        ws = '{32'h00008000, 32'h00008000, 32'h00018000, 32'hFFFF0000};
        pe = '{32'h00000000, 32'hFFFFFFFF, 32'h00024000, 32'h00010000};
        run_job("round", 0);

        xs = '{32'h00010000, 32'h00020000, 32'hFFFE8000, 32'h00008000};
        ws = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
        pe = '{32'h00010000, 32'h00020000, 32'hFFFE8000, 32'h00008000};
        run_job("busy_start", 1);

        // start held high: done every 6 cycles, products hold between pulses
        pa = '{32'h00028000, 32'h00050000, 32'hFFFC4000, 32'h00014000};
        pb = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFE8000};
        @(negedge clk);
        xs = '{32'h00010000, 32'h00020000, 32'hFFFE8000, 32'h00008000};
        ws = '{32'h00028000, 32'h00028000, 32'h00028000, 32'h00028000};
        drive_ops(xs, ws);
        start = 1'b1;
        ndone = 0;
        last  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    chk_prods("b2b_a", pa);
                    last = cyc;
                    xs = '{32'h7FFF0000, 32'h80000000, 32'h80000000, 32'h00030000};
                    ws = '{32'h00020000, 32'h00020000, 32'hFFFF0000, 32'hFFFF8000};
                    drive_ops(xs, ws);
                end else begin
                    chk("b2b_gap", cyc - last, 32'd6);
                    chk_prods("b2b_b", pb);
                    break;
                end
            end else if (ndone == 1) begin
                chk("b2b_hold", prod1, pa[1]);
            end
        end
        start = 1'b0;
        chk("b2b_pulses", ndone, 32'd2);
        repeat (2) @(negedge clk);
        chk("b2b_idle", {31'd0, busy}, 32'd0);

        // reset asserted mid-job at T+3 aborts it
        xs = '{32'h00010000, 32'h00020000, 32'hFFFE8000, 32'h00008000};
        ws = '{32'h00028000, 32'h00028000, 32'h00028000, 32'h00028000};
        drive_ops(xs, ws);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pe = '{32'h0, 32'h0, 32'h0, 32'h0};
        chk_prods("rst_mid", pe);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_mid_nodone", ndone, 32'd0);
        prev_p = pe;
        pe = '{32'h00028000, 32'h00050000, 32'hFFFC4000, 32'h00014000};
        run_job("fresh", 0);
        chk("sum", prod0 + prod1 + prod2 + prod3, 32'h00050000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
